// File: rtl/xocc_pkg.sv
// Shared definitions for the XOCC DSA endpoint: opcodes, command field layout,
// response tags and the controller state encoding.
package xocc_pkg;

    localparam logic [3:0] XOCC_OP_NOP   = 4'h0;
    localparam logic [3:0] XOCC_OP_WRITE = 4'h1;
    localparam logic [3:0] XOCC_OP_READ  = 4'h2;
    localparam logic [3:0] XOCC_OP_ADD   = 4'h3;
    localparam logic [3:0] XOCC_OP_DELAY = 4'h4;

    localparam int CMD_OP_LSB  = 28;
    localparam int CMD_IDX_LSB = 24;
    localparam int CMD_IMM_LSB = 0;
    localparam int CMD_OP_W    = 4;
    localparam int CMD_IDX_W   = 4;
    localparam int CMD_IMM_W   = 24;

    localparam logic [31:0] XOCC_RSP_ACK     = 32'h0000_0001;
    localparam logic [7:0]  XOCC_RSP_DLY_TAG = 8'hD0;
    localparam logic [15:0] XOCC_RSP_ERR_TAG = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DELAY,
        ST_RESP
    } state_t;

    function automatic logic [31:0] sext_imm(input logic [CMD_IMM_W-1:0] imm);
        return {{(32 - CMD_IMM_W){imm[CMD_IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/xocc_regfile.sv
// Local register file of the endpoint: one write port, one combinational read port.
module xocc_regfile #(
    parameter int NREG   = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(waddr) < NREG)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < NREG) ? regs[raddr] : '0;

endmodule

// File: rtl/xocc_dsa_endpoint.sv
// DSA-side XOCC endpoint: pops commands from the cmd FIFO, executes them on the
// local register file and pushes one response per non-NOP command.
//
//   state | meaning
//   IDLE  | waiting for a command; pops one when the cmd FIFO is not empty
//   FETCH | popped word arrives from the FIFO and is captured
//   EXEC  | decode, regfile update, response formed, cmd_cnt++
//   DELAY | down-counting the DELAY immediate
//   RESP  | pushing the response, held while the rsp FIFO is full
module xocc_dsa_endpoint
    import xocc_pkg::*;
#(
    parameter int CMD_W = 32,
    parameter int RSP_W = 32,
    parameter int NREG  = 16,
    parameter int DLY_W = 24
) (
    input  logic             xocc_clk,
    input  logic             xocc_rst,
    input  logic [CMD_W-1:0] xocc_cmd_buffer,
    input  logic             xocc_cmd_empty,
    output logic             xocc_cmd_rd_en,
    output logic [RSP_W-1:0] xocc_rsp_buffer,
    input  logic             xocc_rsp_full,
    output logic             xocc_rsp_wr_en,
    output logic [15:0]      cmd_cnt,
    output logic [7:0]       err_cnt
);

    state_t             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q;
    logic [RSP_W-1:0]   rsp_q, rsp_d;
    logic [DLY_W-1:0]   dly_q;
    logic [15:0]        cmd_cnt_q;
    logic [7:0]         err_cnt_q;

    logic [CMD_OP_W-1:0]  op;
    logic [CMD_IDX_W-1:0] idx;
    logic [CMD_IMM_W-1:0] imm;
    logic [31:0]          imm_sx;
    logic [31:0]          rf_rdata;
    logic [31:0]          rf_wdata;
    logic [31:0]          add_sum;
    logic                 rf_we;
    logic                 cmd_err;

    assign op      = cmd_q[CMD_OP_LSB  +: CMD_OP_W];
    assign idx     = cmd_q[CMD_IDX_LSB +: CMD_IDX_W];
    assign imm     = cmd_q[CMD_IMM_LSB +: CMD_IMM_W];
    assign imm_sx  = sext_imm(imm);
    assign add_sum = rf_rdata + imm_sx;
    assign cmd_err = (op > XOCC_OP_DELAY) || (int'(idx) >= NREG);

    xocc_regfile #(
        .NREG   (NREG),
        .DATA_W (32),
        .ADDR_W (CMD_IDX_W)
    ) u_regfile (
        .clk   (xocc_clk),
        .rst   (xocc_rst),
        .we    (rf_we),
        .waddr (idx),
        .wdata (rf_wdata),
        .raddr (idx),
        .rdata (rf_rdata)
    );

    always_comb begin
        state_d  = state_q;
        rsp_d    = rsp_q;
        rf_we    = 1'b0;
        rf_wdata = imm_sx;
        case (state_q)
            ST_IDLE: begin
                if (!xocc_cmd_empty) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_RESP;
                if (cmd_err) begin
                    rsp_d = RSP_W'({XOCC_RSP_ERR_TAG, 4'h0, op, idx, 4'h0});
                end else begin
                    case (op)
                        XOCC_OP_NOP:   state_d = ST_IDLE;
                        XOCC_OP_WRITE: begin
                            rf_we = 1'b1;
                            rsp_d = RSP_W'(XOCC_RSP_ACK);
                        end
                        XOCC_OP_READ:  rsp_d = RSP_W'(rf_rdata);
                        XOCC_OP_ADD: begin
                            rf_we    = 1'b1;
                            rf_wdata = add_sum;
                            rsp_d    = RSP_W'(add_sum);
                        end
                        XOCC_OP_DELAY: begin
                            rsp_d = RSP_W'({XOCC_RSP_DLY_TAG, imm});
                            if (imm != '0) state_d = ST_DELAY;
                        end
                        default: state_d = ST_RESP;
                    endcase
                end
            end
            ST_DELAY: begin
                if (dly_q == DLY_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!xocc_rsp_full) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge xocc_clk) begin
        if (xocc_rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            rsp_q     <= '0;
            dly_q     <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            if (state_q == ST_FETCH) cmd_q <= xocc_cmd_buffer;
            if (state_q == ST_EXEC) begin
                dly_q     <= DLY_W'(imm);
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
                if (cmd_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (state_q == ST_DELAY) begin
                dly_q <= dly_q - DLY_W'(1);
            end
        end
    end

    // Handshakes are gated by reset so nothing pops or pushes while it is held.
    assign xocc_cmd_rd_en  = !xocc_rst && (state_q == ST_IDLE) && !xocc_cmd_empty;
    assign xocc_rsp_wr_en  = !xocc_rst && (state_q == ST_RESP) && !xocc_rsp_full;
    assign xocc_rsp_buffer = rsp_q;
    assign cmd_cnt         = cmd_cnt_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_xocc_dsa_endpoint.sv
// Scoreboard bench for xocc_dsa_endpoint: directed commands with hand-computed responses.
module tb_xocc_dsa_endpoint;

    logic        xocc_clk = 1'b0;
    logic        xocc_rst;
    logic [31:0] xocc_cmd_buffer;
    logic        xocc_cmd_empty;
    logic        xocc_cmd_rd_en;
    logic [31:0] xocc_rsp_buffer;
    logic        xocc_rsp_full;
    logic        xocc_rsp_wr_en;
    logic [15:0] cmd_cnt;
    logic [7:0]  err_cnt;

    always #5 xocc_clk = ~xocc_clk;

    xocc_dsa_endpoint dut (
        .xocc_clk        (xocc_clk),
        .xocc_rst        (xocc_rst),
        .xocc_cmd_buffer (xocc_cmd_buffer),
        .xocc_cmd_empty  (xocc_cmd_empty),
        .xocc_cmd_rd_en  (xocc_cmd_rd_en),
        .xocc_rsp_buffer (xocc_rsp_buffer),
        .xocc_rsp_full   (xocc_rsp_full),
        .xocc_rsp_wr_en  (xocc_rsp_wr_en),
        .cmd_cnt         (cmd_cnt),
        .err_cnt         (err_cnt)
    );

    logic [31:0] cmd_mem [64];
    logic [31:0] exp_mem [64];
    int push_cnt = 0;
    int pop_cnt = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    int cyc = 0;
    int last_rd = 0;
    int exp_lat = 3;
    int n_checks = 0;
    int n_fail = 0;
    int probe_seq = 0;
    int probe_done = 0;
    int probe_pend = 0;
    logic [15:0] probe_cmd = '0;
    logic [7:0]  probe_err = '0;

    assign xocc_cmd_empty = (push_cnt == pop_cnt);

    // cmd FIFO model: read data appears the cycle after an accepted pop
    initial begin
        xocc_cmd_buffer = '0;
        forever begin
            @(posedge xocc_clk);
            cyc <= cyc + 1;
            if (xocc_cmd_rd_en) begin
                xocc_cmd_buffer <= cmd_mem[pop_cnt[5:0]];
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every push and services counter probes
    initial begin
        forever begin
            @(negedge xocc_clk);
            if (xocc_rst) begin
                chk("rst_rd_en", 32'(xocc_cmd_rd_en), 32'd0);
                chk("rst_wr_en", 32'(xocc_rsp_wr_en), 32'd0);
            end else begin
                if (xocc_cmd_rd_en) begin
                    chk("rd_while_empty", 32'(xocc_cmd_empty), 32'd0);
                    last_rd = cyc;
                end
                if (xocc_rsp_wr_en) begin
                    chk("wr_while_full", 32'(xocc_rsp_full), 32'd0);
                    if (exp_rd == exp_wr) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_push: got %h expected no push", xocc_rsp_buffer);
                    end else begin
                        chk("rsp_data", xocc_rsp_buffer, exp_mem[exp_rd[5:0]]);
                        chk("rd_to_wr_latency", 32'(cyc - last_rd), 32'(exp_lat));
                        exp_rd++;
                    end
                end else if (xocc_rsp_full && (exp_rd != exp_wr) && (cyc - last_rd >= 3)) begin
                    chk("rsp_hold_while_full", xocc_rsp_buffer, exp_mem[exp_rd[5:0]]);
                end
            end
            if (probe_seq != probe_done) begin
                chk("cmd_cnt", 32'(cmd_cnt), 32'(probe_cmd));
                chk("err_cnt", 32'(err_cnt), 32'(probe_err));
                chk("pending_rsp", 32'(exp_wr - exp_rd), 32'(probe_pend));
                probe_done = probe_seq;
            end
        end
    end

    task automatic tick();
        @(posedge xocc_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] c, input bit has_rsp, input logic [31:0] r);
        cmd_mem[push_cnt[5:0]] = c;
        if (has_rsp) begin
            exp_mem[exp_wr[5:0]] = r;
            exp_wr++;
        end
        push_cnt++;
    endtask

    // bounded wait for all commands popped and all responses seen
    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if ((exp_rd == exp_wr) && (pop_cnt == push_cnt)) break;
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic probe(input logic [15:0] c, input logic [7:0] e, input int pend);
        probe_cmd  = c;
        probe_err  = e;
        probe_pend = pend;
        probe_seq++;
        tick();
        tick();
    endtask

    initial begin
        xocc_rst      = 1'b1;
        xocc_rsp_full = 1'b0;

        // reset with a non-empty cmd FIFO, then WRITE/READ of reg3
        push_cmd(32'h13FF_FFFF, 1'b1, 32'h0000_0001);
        push_cmd(32'h2300_0000, 1'b1, 32'hFFFF_FFFF);
        repeat (3) tick();
        xocc_rst = 1'b0;
        probe(16'd0, 8'd0, 2);
        drain();
        probe(16'd2, 8'd0, 0);

        // sign-extended write then two ADDs
        push_cmd(32'h157F_FFFF, 1'b1, 32'h0000_0001);
        push_cmd(32'h3500_0001, 1'b1, 32'h0080_0000);
        push_cmd(32'h3500_0001, 1'b1, 32'h0080_0001);
        drain();
        probe(16'd5, 8'd0, 0);

        // DELAY 16 with rsp FIFO full through 5 RESP cycles
        exp_lat = 24;
        push_cmd(32'h4000_0010, 1'b1, 32'hD000_0010);
        repeat (3) tick();
        xocc_rsp_full = 1'b1;
        repeat (21) tick();
        xocc_rsp_full = 1'b0;
        drain();
        exp_lat = 3;
        probe(16'd6, 8'd0, 0);

        // errors, NOP and overflowing ADD from a fresh reset
        xocc_rst = 1'b1;
        repeat (2) tick();
        xocc_rst = 1'b0;
        probe(16'd0, 8'd0, 0);
        push_cmd(32'hF000_0000, 1'b1, 32'hDEAD_0F00);
        push_cmd(32'h0000_0000, 1'b0, 32'h0);
        push_cmd(32'h2000_0000, 1'b1, 32'h0000_0000);
        drain();
        probe(16'd3, 8'd1, 0);
        push_cmd(32'h5300_0000, 1'b1, 32'hDEAD_0530);
        push_cmd(32'h2300_0000, 1'b1, 32'h0000_0000);
        push_cmd(32'h11FF_FFFF, 1'b1, 32'h0000_0001);
        push_cmd(32'h3100_0001, 1'b1, 32'h0000_0000);
        push_cmd(32'h2100_0000, 1'b1, 32'h0000_0000);
        drain();
        probe(16'd8, 8'd2, 0);

        // reset in the middle of a DELAY: its response must never appear
        push_cmd(32'h4000_0010, 1'b0, 32'h0);
        repeat (8) tick();
        xocc_rst = 1'b1;
        repeat (2) tick();
        xocc_rst = 1'b0;
        repeat (30) tick();
        probe(16'd0, 8'd0, 0);
        push_cmd(32'h13FF_FFFF, 1'b1, 32'h0000_0001);
        push_cmd(32'h2300_0000, 1'b1, 32'hFFFF_FFFF);
        drain();
        probe(16'd2, 8'd0, 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
